// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit for an in-order pipeline.
// Tracks destination tags of in-flight producers and selects EX operand bypass sources.
module fwd_hazard_unit #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                id_valid,
    input  logic [ADDR_W-1:0]                   id_rs,
    input  logic [ADDR_W-1:0]                   id_rt,
    input  logic                                id_rs_used,
    input  logic                                id_rt_used,
    input  logic [ADDR_W-1:0]                   id_rd,
    input  logic                                id_regwrite,
    input  logic                                id_memread,
    input  logic                                id_memwrite,
    input  logic                                flush,
    input  logic                                stat_clr,
    output logic                                stall,
    output logic [$clog2(DEPTH+1)-1:0]          fwd_a,
    output logic [$clog2(DEPTH+1)-1:0]          fwd_b,
    output logic                                fwd_mem,
    output logic [CNT_W-1:0]                    stall_count
);

    localparam int SEL_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rt;
    } tag_t;

    logic r_vld [0:DEPTH];
    tag_t r_tag [0:DEPTH];

    logic             w_ld_hit_rs;
    logic             w_ld_hit_rt;
    logic             w_load;
    logic [SEL_W-1:0] w_fwd_a;
    logic [SEL_W-1:0] w_fwd_b;
    logic             w_fwd_mem;

    function automatic logic f_match(input logic v, input tag_t t, input logic [ADDR_W-1:0] a);
        return v & t.regwrite & (t.rd == a) & (t.rd != '0);
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // A load in EX cannot supply its value until after MEM, so a reader in ID must wait one cycle.
    // Store data (rt) is exempt: it is picked up later through fwd_mem instead.
    assign w_ld_hit_rs = r_tag[0].memread & f_match(r_vld[0], r_tag[0], id_rs) & id_rs_used;
    assign w_ld_hit_rt = r_tag[0].memread & f_match(r_vld[0], r_tag[0], id_rt) & id_rt_used
                         & ~id_memwrite;
    assign stall       = id_valid & ~flush & (w_ld_hit_rs | w_ld_hit_rt);
    assign w_load      = id_valid & ~stall & ~flush;

    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        if (w_load) begin
            // Descending scan so the nearest (smallest k) producer overwrites older ones.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (id_rs_used && f_match(r_vld[k], r_tag[k], id_rs))
                    w_fwd_a = SEL_W'(k + 1);
                if (id_rt_used && f_match(r_vld[k], r_tag[k], id_rt)
                    && !((k == 0) && r_tag[k].memread && id_memwrite))
                    w_fwd_b = SEL_W'(k + 1);
            end
        end
    end

    assign w_fwd_mem = r_vld[0] & r_tag[0].memwrite & f_match(r_vld[1], r_tag[1], r_tag[0].rt);

    // Control state: tag valids, registered selects, statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= DEPTH; k++) r_vld[k] <= 1'b0;
            fwd_a       <= '0;
            fwd_b       <= '0;
            fwd_mem     <= 1'b0;
            stall_count <= '0;
        end else begin
            r_vld[0] <= w_load;
            for (int k = 1; k <= DEPTH; k++) r_vld[k] <= r_vld[k-1];
            fwd_a   <= w_fwd_a;
            fwd_b   <= w_fwd_b;
            fwd_mem <= w_fwd_mem;
            if (stat_clr)
                stall_count <= '0;
            else if (stall)
                stall_count <= f_sat_inc(stall_count);
        end
    end

    // Tag payloads are qualified by r_vld, so they need no reset.
    always_ff @(posedge clk) begin
        r_tag[0] <= '{regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite,
                      rd: id_rd, rt: id_rt};
        for (int k = 1; k <= DEPTH; k++) r_tag[k] <= r_tag[k-1];
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (DEPTH=2, CNT_W=4) with an expected-result queue.
module tb_fwd_hazard_unit;

    localparam int AW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs = '0;
    logic [AW-1:0] id_rt = '0;
    logic          id_rs_used = 1'b0;
    logic          id_rt_used = 1'b0;
    logic [AW-1:0] id_rd = '0;
    logic          id_regwrite = 1'b0;
    logic          id_memread = 1'b0;
    logic          id_memwrite = 1'b0;
    logic          flush = 1'b0;
    logic          stat_clr = 1'b0;
    logic          stall;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          fwd_mem;
    logic [CW-1:0] stall_count;

    fwd_hazard_unit #(.ADDR_W(AW), .DEPTH(2), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .flush(flush), .stat_clr(stat_clr), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .fwd_mem(fwd_mem), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          rsu;
        logic          rtu;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
        logic          mw;
    } ins_t;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       m;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic ins_t f_alu(input int rd, input int rs, input int rt);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rd = AW'(rd); i.rs = AW'(rs); i.rt = AW'(rt);
        i.rsu = 1'b1; i.rtu = 1'b1; i.rw = 1'b1;
        return i;
    endfunction

    function automatic ins_t f_lw(input int rd, input int rs);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rd = AW'(rd); i.rs = AW'(rs); i.rsu = 1'b1; i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic ins_t f_sw(input int rt, input int rs);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rt = AW'(rt); i.rs = AW'(rs); i.rsu = 1'b1; i.rtu = 1'b1; i.mw = 1'b1;
        return i;
    endfunction

    function automatic ins_t f_nop();
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input ins_t i, input logic fl, input logic clr);
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rs_used = i.rsu; id_rt_used = i.rtu;
        id_rd = i.rd; id_regwrite = i.rw; id_memread = i.mr; id_memwrite = i.mw;
        flush = fl; stat_clr = clr;
    endtask

    // One pipeline cycle: drive ID, check combinational stall mid-cycle, check registered selects after the edge.
    task automatic cyc(input string tag, input ins_t i, input logic fl, input logic clr,
                       input logic es, input logic [1:0] ea, input logic [1:0] eb, input logic em);
        exp_t e;
        drive(i, fl, clr);
        exp_q.push_back('{a: ea, b: eb, m: em});
        @(negedge clk);
        chk({tag, ".stall"}, stall, es);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".fwd_a"}, fwd_a, e.a);
        chk({tag, ".fwd_b"}, fwd_b, e.b);
        chk({tag, ".fwd_mem"}, fwd_mem, e.m);
    endtask

    initial begin
        #2;
        chk("rst.fwd_a", fwd_a, 0);
        chk("rst.fwd_b", fwd_b, 0);
        chk("rst.fwd_mem", fwd_mem, 0);
        chk("rst.count", stall_count, 0);
        chk("rst.stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc("b2b.p",   f_alu(3, 1, 2), 0, 0, 0, 0, 0, 0);
        cyc("b2b.c",   f_alu(4, 3, 5), 0, 0, 0, 1, 0, 0);
        cyc("b2b.n0",  f_nop(),        0, 0, 0, 0, 0, 0);
        cyc("b2b.n1",  f_nop(),        0, 0, 0, 0, 0, 0);

        cyc("d2.p",    f_alu(3, 1, 2), 0, 0, 0, 0, 0, 0);
        cyc("d2.nop",  f_nop(),        0, 0, 0, 0, 0, 0);
        cyc("d2.sub",  f_alu(6, 2, 3), 0, 0, 0, 0, 2, 0);
        cyc("d2.n0",   f_nop(),        0, 0, 0, 0, 0, 0);
        cyc("d2.n1",   f_nop(),        0, 0, 0, 0, 0, 0);

        cyc("near.p1", f_alu(3, 1, 2), 0, 0, 0, 0, 0, 0);
        cyc("near.p2", f_alu(3, 1, 2), 0, 0, 0, 0, 0, 0);
        cyc("near.c",  f_alu(9, 3, 3), 0, 0, 0, 1, 1, 0);
        cyc("near.n0", f_nop(),        0, 0, 0, 0, 0, 0);
        cyc("near.n1", f_nop(),        0, 0, 0, 0, 0, 0);

        chk("lu.count0", stall_count, 0);
        cyc("lu.lw",   f_lw(7, 1),     0, 0, 0, 0, 0, 0);
        cyc("lu.stl",  f_alu(8, 7, 1), 0, 0, 1, 0, 0, 0);
        chk("lu.count1", stall_count, 1);
        cyc("lu.go",   f_alu(8, 7, 1), 0, 0, 0, 2, 0, 0);
        chk("lu.count1b", stall_count, 1);
        cyc("lu.n0",   f_nop(),        0, 0, 0, 0, 0, 0);
        cyc("lu.n1",   f_nop(),        0, 0, 0, 0, 0, 0);

        cyc("st.lw",   f_lw(7, 1),     0, 0, 0, 0, 0, 0);
        cyc("st.sw",   f_sw(7, 2),     0, 0, 0, 0, 0, 0);
        cyc("st.mem",  f_nop(),        0, 0, 0, 0, 0, 1);
        cyc("st.n1",   f_nop(),        0, 0, 0, 0, 0, 0);

        cyc("r0.p",    f_alu(0, 1, 2), 0, 0, 0, 0, 0, 0);
        cyc("r0.c",    f_alu(5, 0, 0), 0, 0, 0, 0, 0, 0);
        cyc("r0.n0",   f_nop(),        0, 0, 0, 0, 0, 0);
        cyc("r0.n1",   f_nop(),        0, 0, 0, 0, 0, 0);

        cyc("fl.lw",   f_lw(7, 1),     0, 0, 0, 0, 0, 0);
        cyc("fl.kill", f_alu(8, 7, 1), 1, 0, 0, 0, 0, 0);
        chk("fl.count", stall_count, 1);
        cyc("fl.old",  f_alu(9, 7, 7), 0, 0, 0, 2, 2, 0);
        cyc("fl.n0",   f_nop(),        0, 0, 0, 0, 0, 0);
        cyc("fl.n1",   f_nop(),        0, 0, 0, 0, 0, 0);

        cyc("sat.clr", f_nop(),        0, 1, 0, 0, 0, 0);
        chk("sat.count0", stall_count, 0);
        for (int n = 1; n <= (1 << CW) + 3; n++) begin
            cyc("sat.lw",  f_lw(7, 1),     0, 0, 0, 0, 0, 0);
            cyc("sat.use", f_alu(8, 7, 1), 0, 0, 1, 0, 0, 0);
            if (n == 10) chk("sat.count10", stall_count, 10);
        end
        chk("sat.full", stall_count, (1 << CW) - 1);
        cyc("clr.lw",  f_lw(7, 1),     0, 0, 0, 0, 0, 0);
        cyc("clr.stl", f_alu(8, 7, 1), 0, 1, 1, 0, 0, 0);
        chk("clr.count", stall_count, 0);

        cyc("ar.lw",   f_lw(7, 1),     0, 0, 0, 0, 0, 0);
        cyc("ar.stl",  f_alu(8, 7, 1), 0, 0, 1, 0, 0, 0);
        cyc("ar.p",    f_alu(3, 1, 2), 0, 0, 0, 0, 0, 0);
        cyc("ar.lw2",  f_lw(7, 3),     0, 0, 0, 1, 0, 0);
        drive(f_alu(8, 7, 1), 0, 0);
        #1;
        chk("ar.pre.stall", stall, 1);
        chk("ar.pre.count", stall_count, 1);
        rst_n = 1'b0;
        #1;
        chk("ar.stall", stall, 0);
        chk("ar.fwd_a", fwd_a, 0);
        chk("ar.fwd_b", fwd_b, 0);
        chk("ar.fwd_mem", fwd_mem, 0);
        chk("ar.count", stall_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar.after.stall", stall, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
